// File: rtl/conv1d_top.sv
// conv1d_top: two-stage pipelined 1-D convolution, per-tap dot products then per-window tap sum
module conv1d_top #(
  parameter int bw      = 8,
  parameter int rows    = 8,
  parameter int cols    = 8,
  parameter int height  = 2,
  parameter int macs    = cols - height + 1,
  parameter int bw_psum = 2 * bw + $clog2(rows)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [rows*bw*cols-1:0]      A,
  input  logic [rows*bw*height-1:0]    kern,
  output logic [bw_psum*macs-1:0]      out
);
  localparam int PW  = 2 * bw + $clog2(rows);
  localparam int SW0 = PW + $clog2(height) + 1;
  localparam int TW  = SW0 > bw_psum ? SW0 : bw_psum;
  logic [PW-1:0] w_p [macs*height];
  logic [PW-1:0] r_p [macs*height];
  logic [TW-1:0] w_s [macs];
  always_comb begin
    for (int m = 0; m < macs; m++)
      for (int k = 0; k < height; k++) begin
        w_p[m*height+k] = '0;
        for (int r = 0; r < rows; r++)
          w_p[m*height+k] = w_p[m*height+k] + PW'(A[(r*cols+m+k)*bw +: bw]) * PW'(kern[(r*height+k)*bw +: bw]);
      end
  end
  // tap sum runs at full width; out keeps only the low bw_psum bits
  always_comb begin
    for (int m = 0; m < macs; m++) begin
      w_s[m] = '0;
      for (int k = 0; k < height; k++)
        w_s[m] = w_s[m] + TW'(r_p[m*height+k]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < macs*height; i++) r_p[i] <= '0;
      out <= '0;
    end else begin
      for (int i = 0; i < macs*height; i++) r_p[i] <= w_p[i];
      for (int m = 0; m < macs; m++) out[m*bw_psum +: bw_psum] <= w_s[m][bw_psum-1:0];
    end
  end
endmodule

// File: tb/tb_conv1d_top.sv
// tb_conv1d_top: directed vectors for conv1d_top with hand-computed window results
module tb_conv1d_top;
  localparam int BW = 8, ROWS = 8, COLS = 8, H = 2, MACS = 7, PS = 19;
  logic clk, rst;
  logic [ROWS*BW*COLS-1:0] A;
  logic [ROWS*BW*H-1:0] kern;
  logic [PS*MACS-1:0] out;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] e [MACS];

  conv1d_top dut (.clk(clk), .rst(rst), .A(A), .kern(kern), .out(out));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int m = 0; m < MACS; m++)
      chk($sformatf("%s[%0d]", tag, m), 32'(out[m*PS +: PS]), e[m]);
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] k);
    for (int i = 0; i < ROWS*COLS; i++) A[i*BW +: BW] = a;
    for (int i = 0; i < ROWS*H; i++) kern[i*BW +: BW] = k;
  endtask

  task automatic set_ramp();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) A[(r*COLS+c)*BW +: BW] = 8'(c + 1);
      kern[(r*H+0)*BW +: BW] = 8'd1;
      kern[(r*H+1)*BW +: BW] = 8'd2;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < ROWS*COLS; i++) A[i*BW +: BW] = 8'($urandom_range(255));
    for (int i = 0; i < ROWS*H; i++) kern[i*BW +: BW] = 8'($urandom_range(255));
  endtask

  task automatic exp_const(input logic [31:0] v);
    for (int m = 0; m < MACS; m++) e[m] = v;
  endtask

  task automatic exp_ramp();
    for (int m = 0; m < MACS; m++) e[m] = 32'(8 * (3*m + 5));
  endtask

  initial begin
    rst = 1;
    set_rand();
    repeat (3) @(negedge clk);
    exp_const(0);
    chk_all("reset_held");
    set_all(1, 1);
    rst = 0;
    @(posedge clk); @(negedge clk);
    chk_all("first_edge_zero");
    set_ramp();
    @(posedge clk); @(negedge clk);
    exp_const(16);
    chk_all("ones");
    @(posedge clk); @(negedge clk);
    exp_ramp();
    chk_all("ramp_pipelined");
    chk("ramp_w0", 32'(out[0 +: PS]), 40);
    chk("ramp_w3", 32'(out[3*PS +: PS]), 112);
    chk("ramp_w6", 32'(out[6*PS +: PS]), 184);
    set_all(255, 255);
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_const(516112);
    chk_all("max_mod");
    rst = 1;
    #1;
    exp_const(0);
    chk_all("async_reset");
    rst = 0;
    set_all(1, 1);
    @(posedge clk); @(negedge clk);
    rst = 1;
    #1;
    chk_all("mid_reset");
    set_ramp();
    @(posedge clk); @(negedge clk);
    chk_all("mid_reset_hold");
    rst = 0;
    @(posedge clk); @(negedge clk);
    chk_all("post_reset_edge1");
    @(posedge clk); @(negedge clk);
    exp_ramp();
    chk_all("post_reset_ramp");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
